// File: rtl/spi_master_driver_if.sv
// rtl/spi_master_driver_if.sv - request/response and SPI pin bundle for spi_master_driver
interface spi_master_driver_if;
    logic       start;
    logic [7:0] data_in;
    logic       ready;
    logic       done;
    logic [7:0] data_out;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;

    modport master (
        input  start, data_in, miso,
        output ready, done, data_out, sclk, cs, mosi
    );

    modport slave (
        output start, data_in, miso,
        input  ready, done, data_out, sclk, cs, mosi
    );
endinterface

// File: rtl/spi_master_driver.sv
// rtl/spi_master_driver.sv - SPI mode 0 master, one 8-bit full-duplex transfer per start
module spi_master_driver #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    spi_master_driver_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;

    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

    state_t     state;
    logic [7:0] phase;
    logic [2:0] bit_cnt;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [7:0] data_out;
    logic       ready;
    logic       done;
    logic       sclk;
    logic       cs;
    logic       phase_last;

    assign phase_last = (phase == PHASE_LAST);

    // tx_shift is zero whenever cs is high, so its MSB doubles as the registered MOSI.
    assign bus.mosi     = tx_shift[7];
    assign bus.sclk     = sclk;
    assign bus.cs       = cs;
    assign bus.ready    = ready;
    assign bus.done     = done;
    assign bus.data_out = data_out;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            data_out <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
            sclk     <= 1'b0;
            cs       <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    phase <= '0;
                    if (bus.start) begin
                        tx_shift <= bus.data_in;
                        rx_shift <= '0;
                        bit_cnt  <= '0;
                        cs       <= 1'b0;
                        ready    <= 1'b0;
                        state    <= LOW;
                    end
                end
                LOW: begin
                    if (phase_last) begin
                        phase    <= '0;
                        sclk     <= 1'b1;
                        rx_shift <= {rx_shift[6:0], bus.miso};
                        state    <= HIGH;
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                HIGH: begin
                    if (phase_last) begin
                        phase <= '0;
                        sclk  <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            state <= HOLD;
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            bit_cnt  <= bit_cnt + 3'd1;
                            state    <= LOW;
                        end
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                HOLD: begin
                    if (phase_last) begin
                        phase    <= '0;
                        cs       <= 1'b1;
                        tx_shift <= '0;
                        data_out <= rx_shift;
                        done     <= 1'b1;
                        state    <= GAP;
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                GAP: begin
                    // Keeps CS high long enough for the slave to fall back to idle.
                    if (phase_last) begin
                        phase <= '0;
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        phase <= phase + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
